// File: rtl/mod_accum_stream_if.sv
// rtl/mod_accum_stream_if.sv - input/output handshake bundle for mod_accum_stream
interface mod_accum_stream_if #(
    parameter int WIDTH = 7
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_mode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_wrap;

    // Producer/consumer side that drives operands and accepts results
    modport master (
        output in_valid,
        output in_data,
        output in_mode,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  out_wrap
    );

    // The reduction stage itself
    modport slave (
        input  in_valid,
        input  in_data,
        input  in_mode,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data,
        output out_wrap
    );
endinterface

// File: rtl/mod_accum_stream.sv
// rtl/mod_accum_stream.sv - modular map/accumulate stream stage; MOD_ACCUM_STREAM_WRAP_CNT_EN adds wrap_cnt
module mod_accum_stream #(
    parameter int          WIDTH   = 7,
    parameter logic [64:0] MODULUS = 65'd100,
    parameter logic [63:0] STEP    = 64'd1
) (
    input  logic               clk,
    input  logic               rst,
    mod_accum_stream_if.slave  bus
`ifdef MOD_ACCUM_STREAM_WRAP_CNT_EN
    ,
    output logic [15:0]        wrap_cnt
`endif
);

    // Operands widened by one bit so the sum never truncates
    localparam logic [WIDTH:0] mod_ext  = MODULUS[WIDTH:0];
    localparam logic [WIDTH:0] step_ext = {1'b0, STEP[WIDTH-1:0]};

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] acc;
    logic [WIDTH:0]   addend;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] reduced;
    logic             wrap;
    logic             in_fire;
    logic             out_fire;

    // The output register is the only storage, so validity is the state itself
    assign bus.out_valid = (state == FULL);
    // One-deep skid-free register: accept whenever the slot is free or draining now
    assign bus.in_ready  = !bus.out_valid || bus.out_ready;
    assign in_fire       = bus.in_valid && bus.in_ready;
    assign out_fire      = bus.out_valid && bus.out_ready;

    // Unreduced sum, wrap flag and full modulo for any operand, including ones >= MODULUS
    always_comb begin
        addend  = bus.in_mode ? {1'b0, acc} : step_ext;
        sum     = addend + {1'b0, bus.in_data};
        wrap    = (sum >= mod_ext);
        reduced = WIDTH'(sum % mod_ext);
    end

    // EMPTY/FULL control with registered result and accumulator update on accept
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= EMPTY;
            bus.out_data <= '0;
            bus.out_wrap <= 1'b0;
            acc          <= '0;
        end else begin
            case (state)
                EMPTY: begin
                    if (in_fire) begin
                        bus.out_data <= reduced;
                        bus.out_wrap <= wrap;
                        if (bus.in_mode) begin
                            acc <= reduced;
                        end
                        state <= FULL;
                    end
                end
                FULL: begin
                    if (in_fire) begin
                        bus.out_data <= reduced;
                        bus.out_wrap <= wrap;
                        if (bus.in_mode) begin
                            acc <= reduced;
                        end
                        state <= FULL;
                    end else if (out_fire) begin
                        state <= EMPTY;
                    end
                end
                default: begin
                    state <= EMPTY;
                end
            endcase
        end
    end

`ifdef MOD_ACCUM_STREAM_WRAP_CNT_EN
    // Count delivered results that wrapped; free-running 16-bit rollover
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrap_cnt <= 16'd0;
        end else if (out_fire && bus.out_wrap) begin
            wrap_cnt <= wrap_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: doc/mod_accum_stream.md
MOD_ACCUM_STREAM -- requirements
Module: mod_accum_stream

Interface
REQ-001 Parameter WIDTH, default 7, data width in bits (2..64).
REQ-002 Parameter MODULUS, default 100, reduction modulus (2..2^WIDTH).
REQ-003 Parameter STEP, default 1, map-mode increment (0..2^WIDTH-1).
REQ-004 clk  input  1  clock; all state SHALL change on rising edge only, except reset.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 in_valid  input  1  in_data/in_mode valid.
REQ-007 in_ready  output  1  block accepts input this cycle.
REQ-008 in_data  input  WIDTH  operand; any value 0..2^WIDTH-1 is legal, including values >= MODULUS.
REQ-009 in_mode  input  1  0 = map, 1 = accumulate.
REQ-010 out_valid  output  1  out_data/out_wrap valid.
REQ-011 out_ready  input  1  consumer accepts output this cycle.
REQ-012 out_data  output  WIDTH  reduced result, always < MODULUS.
REQ-013 out_wrap  output  1  unreduced sum was >= MODULUS.

Function
REQ-014 Transfer in: in_valid && in_ready at rising edge; transfer out: out_valid && out_ready at rising edge.
REQ-015 in_ready SHALL equal !out_valid || out_ready (combinational, one-deep output register, no bubble under full throughput).
REQ-016 Map mode: out_data = (in_data + STEP) mod MODULUS; out_wrap = (in_data + STEP) >= MODULUS; accumulator unchanged.
REQ-017 Accumulate mode: s = acc + in_data; out_data = s mod MODULUS; acc <= s mod MODULUS; out_wrap = s >= MODULUS.
REQ-018 Sums SHALL be formed at WIDTH+1 bits with no truncation; result SHALL equal the mathematical modulo for every legal operand.
REQ-019 Accumulator acc (WIDTH bits) SHALL always be < MODULUS.
REQ-020 Latency: result registered; out_valid rises the cycle after the accepting edge.
REQ-021 FSM states EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-022 EMPTY -> FULL on input transfer; FULL -> EMPTY on output transfer without input transfer; FULL -> FULL, new result loaded, on simultaneous input and output transfer.
REQ-023 In FULL with out_ready=0: out_data, out_wrap held stable, in_ready=0, acc unchanged.
REQ-024 Back-to-back accumulate transfers SHALL each use the acc value updated by the previous transfer (no stale read).
REQ-025 in_mode SHALL be sampled only on input transfer; modes may alternate per transfer.

Reset
REQ-026 rst asserted: state EMPTY, out_valid=0, out_data=0, out_wrap=0, acc=0 immediately, independent of clk.
REQ-027 Reset mid-operation SHALL discard the held output; no transfer occurs at an edge where rst is high.
REQ-028 First input transfer after reset release SHALL behave identically to first transfer after power-up.

Configuration
REQ-029 Macro MOD_ACCUM_STREAM_WRAP_CNT_EN defined: extra port wrap_cnt output 16, counts output transfers with out_wrap=1, wraps 65535 -> 0, reset 0.
REQ-030 Macro undefined: port wrap_cnt and its counter SHALL not exist; all other behaviour identical.

Verification (WIDTH=7, MODULUS=100, STEP=1)
REQ-031 Map 99, out_ready=1 -> next cycle out_data=0, out_wrap=1; map 42 -> 43, out_wrap=0.
REQ-032 Map 127 -> out_data=28, out_wrap=1 (out-of-range operand).
REQ-033 Accumulate 60, 50, 95 back-to-back, out_ready=1 -> out_data 60, 10, 5; out_wrap 0, 1, 1; in_ready held 1.
REQ-034 out_ready=0, two inputs offered -> first accepted, in_ready=0 thereafter, out_data held; out_ready=1 -> first drains same edge second is accepted.
REQ-035 Accumulate 70, assert rst while FULL -> out_valid=0 immediately; after release accumulate 20 -> out_data=20.
REQ-036 With MOD_ACCUM_STREAM_WRAP_CNT_EN: map 99 three times -> wrap_cnt=3; with out_ready=0 held, wrap_cnt unchanged until drain.
